// File: rtl/adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding and
// the bit-counter width derived from the operand width.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=2.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder.sv
// The one full-adder cell that the serial adder reuses for every bit position.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

  assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder; two of these plus an OR make the shared full adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, one bit per clock.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic [1:0]       dbg_state
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             start_ready_q;
  logic             busy_q;
  logic             done_valid_q;

  logic fa_s;
  logic fa_c;

  full_adder u_fa (
    .a   (shift_a_q[0]),
    .b   (shift_b_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .cout(fa_c)
  );

  always_comb begin
    state_d   = state_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    sum_sh_d  = sum_sh_q;
    carry_d   = carry_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          shift_a_d = a_in;
          shift_b_d = b_in;
          carry_d   = cin;
          bit_cnt_d = '0;
          sum_sh_d  = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        sum_sh_d  = {fa_s, sum_sh_q[WIDTH-1:1]};
        shift_a_d = shift_a_q >> 1;
        shift_b_d = shift_b_q >> 1;
        carry_d   = fa_c;
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (bit_cnt_q == LAST_BIT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (done_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shift_a_q     <= '0;
      shift_b_q     <= '0;
      sum_sh_q      <= '0;
      carry_q       <= 1'b0;
      bit_cnt_q     <= '0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      done_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_a_q     <= shift_a_d;
      shift_b_q     <= shift_b_d;
      sum_sh_q      <= sum_sh_d;
      carry_q       <= carry_d;
      bit_cnt_q     <= bit_cnt_d;
      start_ready_q <= (state_d == IDLE);
      busy_q        <= (state_d == RUN) || (state_d == DONE);
      done_valid_q  <= (state_d == DONE);
    end
  end

  assign start_ready = start_ready_q;
  assign busy        = busy_q;
  assign done_valid  = done_valid_q;
  assign sum_out     = sum_sh_q;
  assign cout_out    = carry_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial W-bit adder controller that shares one full-adder cell across every bit position. It accepts two operands and a carry-in through a valid/ready handshake and processes one bit per clock, LSB first. It returns the W-bit sum and carry-out through a second valid/ready handshake. It sits beside the combinational adder library as the area-minimal option: one adder cell plus shift registers, traded against W cycles of latency.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start_valid  input  1  requester presents a_in, b_in, cin.
- start_ready  output  1  high only in IDLE; a transfer occurs when start_valid and start_ready are both high at an edge.
- a_in  input  WIDTH  operand A, sampled on the accept edge only.
- b_in  input  WIDTH  operand B, sampled on the accept edge only.
- cin  input  1  carry-in, sampled on the accept edge only.
- busy  output  1  high in RUN and DONE.
- done_valid  output  1  result available; high only in DONE.
- done_ready  input  1  consumer takes the result.
- sum_out  output  WIDTH  result sum; stable while done_valid is high.
- cout_out  output  1  result carry-out; stable while done_valid is high.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On accept: load shift_a<=a_in, shift_b<=b_in, carry<=cin, bit_cnt<=0, sum_sh<=0; next state RUN.
- RUN, each edge:
  - Compute {c,s} = full_adder(shift_a[0], shift_b[0], carry).
  - sum_sh <= {s, sum_sh[WIDTH-1:1]}.
  - shift_a and shift_b shift right, zero-filled.
  - carry <= c.
  - bit_cnt <= bit_cnt+1.
  - On the edge where bit_cnt==WIDTH-1, go to DONE.
- DONE:
  - done_valid=1; sum_out=sum_sh; cout_out=carry.
  - All registers hold.
  - When done_ready is high at an edge, go to IDLE.
- start_valid is ignored outside IDLE, and operand inputs are never re-sampled mid-operation.
- Arithmetic: {cout_out, sum_out} = a_in + b_in + cin, exact modulo 2^(WIDTH+1). No overflow flag.
- bit_cnt width is $clog2(WIDTH). There is no wrap inside one operation, because the exit happens at WIDTH-1.

## Timing
- Reset (rst_n low at an edge):
  - State goes to IDLE.
  - start_ready=1, busy=0, done_valid=0, sum_out=0, cout_out=0.
  - Any in-flight operation is discarded and produces no done_valid.
  - Reset takes priority over every other event on the same edge.
- Latency: accept at edge E0. Bits are processed at E1..EW. done_valid rises after EW, i.e. W cycles after acceptance.
- done_valid stays high with stable outputs for as long as done_ready is low. There is no timeout.
- DONE lasts a minimum of 1 cycle. The next start can be accepted at the edge after returning to IDLE, so peak throughput is one operation per W+2 cycles.
- done_ready high while not in DONE has no effect.
- start_valid held high through a whole operation causes exactly one new accept, and only once the block is back in IDLE.
- start_ready and done_valid are never high in the same cycle.

## Structure
- Shared package adder_pkg:
  - State enum encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - A function returning the bit_cnt width for a given WIDTH.
- One sub-module, full_adder (a, b, cin -> s, cout), built from two HA instances plus an OR gate. It is instantiated exactly once.
- The top level holds the FSM, shift registers, carry flop and counter.

## Test plan
- WIDTH=8, a=0x00, b=0x00, cin=0:
  - done_valid rises exactly 8 cycles after accept.
  - sum_out=0x00, cout_out=0.
- a=0xFF, b=0x01, cin=0: sum_out=0x00, cout_out=1. This exercises the full carry ripple.
- a=0xA5, b=0x5A, cin=1: sum_out=0x00, cout_out=1.
- Back-pressure, with a=0x12, b=0x34:
  - Hold done_ready=0 for 5 cycles after done_valid rises. sum_out must stay 0x46 with done_valid high throughout.
  - Raise done_ready: the block returns to IDLE and start_ready=1 on the next cycle.
- Hold start_valid=1 with new operands during RUN:
  - The first result is unaffected.
  - The second operation is accepted only after IDLE is re-entered.
- Assert rst_n=0 for one edge at bit_cnt=4:
  - All outputs are 0 and start_ready=1 on the next cycle.
  - No done_valid appears for the aborted operation.
  - A following a=0x0F, b=0x01 accept returns 0x10, cout_out=0.
